// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
  parameter int PHY_LEN  = 20,
  parameter int LINE_LEN = 128,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [PHY_LEN-1:0]  ic_addr,
  output logic                ic_valid,
  output logic [LINE_LEN-1:0] ic_data,
  output logic                ic_err,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [PHY_LEN-1:0]  dc_addr,
  input  logic [LINE_LEN-1:0] dc_wdata,
  output logic                dc_valid,
  output logic [LINE_LEN-1:0] dc_data,
  output logic                dc_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [PHY_LEN-1:0]  mem_addr,
  output logic [LINE_LEN-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [LINE_LEN-1:0] mem_rdata,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam int          WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]          state;
  logic                last_owner;
  logic                owner;
  logic                we_q;
  logic [PHY_LEN-1:0]  addr_q;
  logic [LINE_LEN-1:0] wdata_q;
  logic [WD_W-1:0]     wdog;
  logic [LINE_LEN-1:0] data_q;
  logic                err_q;
  logic                grant_dc;

  // On contention the requester that did not go last wins.
  always_comb begin
    grant_dc = 1'b0;
    if (ic_req && dc_req)
      grant_dc = (last_owner == OWN_IC);
    else
      grant_dc = dc_req;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_owner <= OWN_DC;
      owner      <= OWN_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdog       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ic_req || dc_req) begin
            owner <= grant_dc ? OWN_DC : OWN_IC;
            if (grant_dc) begin
              addr_q  <= dc_addr;
              we_q    <= dc_we;
              wdata_q <= dc_we ? dc_wdata : '0;
            end else begin
              addr_q  <= ic_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            wdog  <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A late ack in the final watchdog cycle still completes normally.
          if (mem_ack) begin
            data_q <= we_q ? '0 : mem_rdata;
            err_q  <= 1'b0;
            state  <= S_RESP;
          end else if (wdog == WD_LAST) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= S_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          last_owner <= owner;
          wdog       <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign mem_req   = (state == S_ISSUE);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign ic_valid = (state == S_RESP) && (owner == OWN_IC);
  assign dc_valid = (state == S_RESP) && (owner == OWN_DC);
  assign ic_data  = ic_valid ? data_q : '0;
  assign dc_data  = dc_valid ? data_q : '0;
  assign ic_err   = ic_valid & err_q;
  assign dc_err   = dc_valid & err_q;

endmodule
